// File: rtl/ram_fill_engine_pkg.sv
// Shared types for the RAM fill/check engine: FSM states, operation mode
// and the byte-enable pattern used for full-word writes.
package ram_fill_engine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_FILL  = 1'b0,
    MODE_CHECK = 1'b1
  } mode_e;

  localparam logic [3:0] WE_WORD = 4'hf;

  // Operation controls captured at an accepted start.
  typedef struct packed {
    mode_e mode;
    logic  incr;
  } op_cfg_t;

endpackage

// File: rtl/ram_fill_engine.sv
// Bus initiator that fills a RAM word range with a constant or incrementing
// pattern, or verifies a range against the same pattern.
module ram_fill_engine
  import ram_fill_engine_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic              incr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] error_addr,
  input  logic              mem_grant,
  output logic              mem_cs,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_ready
);

  state_e            r_state;
  state_e            w_next_state;
  op_cfg_t           r_cfg;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_abort;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W-1:0] r_error_addr;

  logic w_accept;
  logic w_zero_count;
  logic w_access_done;
  logic w_mismatch;
  logic w_stop;

  assign w_accept      = (r_state == IDLE) && start;
  assign w_zero_count  = (word_count == '0);
  assign w_access_done = (r_state == WAIT) && mem_ready;
  assign w_mismatch    = w_access_done && (r_cfg.mode == MODE_CHECK) &&
                         (mem_read_data != r_data);
  // A pending abort may arrive in the same cycle as the completing ready.
  assign w_stop        = w_access_done &&
                         (w_mismatch || (r_remaining == CNT_W'(1)) || r_abort || abort);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    mem_cs       = 1'b0;
    mem_we       = 4'h0;
    case (r_state)
      IDLE: begin
        if (start && !w_zero_count) w_next_state = ISSUE;
      end
      ISSUE: begin
        if (mem_grant) begin
          mem_cs       = 1'b1;
          mem_we       = (r_cfg.mode == MODE_FILL) ? WE_WORD : 4'h0;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (mem_ready) w_next_state = w_stop ? IDLE : ISSUE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cfg        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_remaining  <= '0;
      r_abort      <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_addr <= '0;
    end else begin
      r_done <= w_stop || (w_accept && w_zero_count);

      if (w_accept) begin
        r_error      <= 1'b0;
        r_error_addr <= '0;
        if (!w_zero_count) begin
          r_cfg.mode  <= mode_e'(mode);
          r_cfg.incr  <= incr;
          r_addr      <= base_addr;
          r_data      <= pattern;
          r_remaining <= word_count;
        end
      end

      if (w_stop) begin
        r_abort <= 1'b0;
      end else if ((r_state != IDLE) && abort) begin
        r_abort <= 1'b1;
      end

      // Address and data only advance once the current access has completed.
      if (w_access_done) begin
        r_remaining <= r_remaining - 1'b1;
        if (w_mismatch) begin
          r_error      <= 1'b1;
          r_error_addr <= r_addr;
        end
        if (!w_stop) begin
          r_addr <= r_addr + 1'b1;
          if (r_cfg.incr) r_data <= r_data + 32'd1;
        end
      end
    end
  end

  assign busy           = (r_state != IDLE);
  assign done           = r_done;
  assign error          = r_error;
  assign error_addr     = r_error_addr;
  assign mem_address    = r_addr;
  assign mem_write_data = r_data;

endmodule

// File: tb/tb_ram_fill_engine.sv
// Bench for ram_fill_engine: RAM responder with ready one cycle after cs,
// a transaction-level reference model compared every cycle, directed cases.
module tb_ram_fill_engine;

  localparam int AW    = 15;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          mode;
  logic          incr;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_count;
  logic [31:0]   pattern;
  logic          abort;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] error_addr;
  logic          mem_grant;
  logic          mem_cs;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data = '0;
  logic          mem_ready     = 1'b0;

  ram_fill_engine #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .mode           (mode),
    .incr           (incr),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .pattern        (pattern),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .error_addr     (error_addr),
    .mem_grant      (mem_grant),
    .mem_cs         (mem_cs),
    .mem_we         (mem_we),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit [31:0]     ram    [DEPTH];
  bit [31:0]     golden [DEPTH];
  logic          inject_en   = 1'b0;
  logic [AW-1:0] inject_addr = '0;
  logic [31:0]   inject_data = '0;

  // RAM responder: ready is cs delayed one cycle; side door for corruption.
  always @(posedge clk) begin
    mem_ready <= mem_cs;
    if (inject_en) begin
      ram[inject_addr] <= inject_data;
    end else if (mem_cs) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
      mem_read_data <= ram[mem_address];
    end
  end

  int n_vec    = 0;
  int n_err    = 0;
  int cs_count = 0;
  bit grant_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one operation = word_count accesses at base+i holding
  // pattern (+i), one outstanding access at a time, stopped by count, abort
  // or the first CHECK mismatch.
  bit            m_busy = 0, m_out = 0, m_mode = 0, m_incr = 0;
  bit            m_abort = 0, m_err = 0, m_done = 0;
  logic [AW-1:0] m_base = '0, m_eaddr = '0;
  logic [31:0]   m_pat = '0;
  int            m_count = 0, m_idx = 0;

  function automatic logic [AW-1:0] m_addr();
    return AW'(int'(m_base) + m_idx);
  endfunction

  function automatic logic [31:0] m_word();
    return m_pat + (m_incr ? 32'(m_idx) : 32'd0);
  endfunction

  initial begin : model
    logic exp_cs;
    forever begin
      @(negedge clk);
      exp_cs = m_busy && !m_out && mem_grant;
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("error", 32'(error), 32'(m_err));
      check("error_addr", 32'(error_addr), 32'(m_eaddr));
      check("mem_cs", 32'(mem_cs), 32'(exp_cs));
      check("mem_we", 32'(mem_we), (exp_cs && !m_mode) ? 32'hf : 32'h0);
      if (m_busy) check("mem_address", 32'(mem_address), 32'(m_addr()));
      if (m_busy && !m_mode) check("mem_write_data", mem_write_data, m_word());
      if (mem_cs) cs_count++;

      if (inject_en) golden[inject_addr] = inject_data;
      if (!reset_n) begin
        m_busy = 0; m_out = 0; m_abort = 0; m_err = 0; m_done = 0; m_eaddr = '0;
      end else begin
        m_done = 0;
        if (!m_busy) begin
          if (start) begin
            m_err = 0;
            m_eaddr = '0;
            if (word_count == 0) begin
              m_done = 1;
            end else begin
              m_busy = 1; m_out = 0; m_abort = 0; m_idx = 0;
              m_mode = mode; m_incr = incr; m_base = base_addr;
              m_count = int'(word_count); m_pat = pattern;
            end
          end
        end else if (!m_out) begin
          if (abort) m_abort = 1;
          if (mem_grant) begin
            m_out = 1;
            if (!m_mode) golden[m_addr()] = m_word();
          end
        end else if (mem_ready) begin
          m_out = 0;
          if (m_mode && golden[m_addr()] != m_word()) begin
            m_err = 1; m_eaddr = m_addr(); m_busy = 0; m_done = 1;
          end else begin
            m_idx++;
            if (m_idx == m_count || m_abort || abort) begin
              m_busy = 0; m_done = 1;
            end
          end
        end else if (abort) begin
          m_abort = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (grant_rand) mem_grant = ($urandom_range(0, 3) != 0);
  endtask

  task automatic inject(input logic [AW-1:0] a, input logic [31:0] d);
    inject_addr = a;
    inject_data = d;
    inject_en   = 1'b1;
    tick();
    inject_en   = 1'b0;
  endtask

  // lat = clock edges after the edge that samples start until done is seen.
  task automatic run_op(input bit md, input bit inc, input logic [AW-1:0] base,
                        input logic [CW-1:0] cnt, input logic [31:0] pat,
                        input int abort_at, input int restart_at, input int glow_at,
                        output int lat, output int ncs);
    int c0;
    mode = md; incr = inc; base_addr = base; word_count = cnt; pattern = pat;
    start = 1'b1;
    c0 = cs_count;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 2000) begin
      abort = (lat == abort_at);
      if (lat == restart_at) begin
        start = 1'b1; mode = ~md; word_count = CW'($urandom_range(0, 5));
        base_addr = AW'($urandom); pattern = $urandom;
      end else begin
        start = 1'b0;
      end
      if (!grant_rand) mem_grant = !(lat >= glow_at && lat < glow_at + 3);
      tick();
      lat++;
    end
    start = 1'b0;
    abort = 1'b0;
    check("op_done", 32'(done), 32'd1);
    check("busy_with_done", 32'(busy), 32'd0);
    ncs = cs_count - c0;
    tick();
  endtask

  initial begin
    int lat, ncs;
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; incr = 1'b0; abort = 1'b0;
    base_addr = '0; word_count = '0; pattern = '0; mem_grant = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cs", 32'(mem_cs), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    reset_n = 1'b1;
    tick();

    // Constant fill of four words.
    run_op(0, 0, 15'h0010, 16'd4, 32'hA5A5A5A5, -1, -1, -100, lat, ncs);
    check("fill_latency", 32'(lat), 32'd8);
    check("fill_accesses", 32'(ncs), 32'd4);
    check("fill_error", 32'(error), 32'd0);
    for (int k = 0; k < 4; k++) check("fill_word", ram[15'h0010 + k], 32'hA5A5A5A5);

    // Incrementing fill across the top-of-memory wrap.
    run_op(0, 1, 15'h7FFE, 16'd4, 32'h0, -1, -1, -100, lat, ncs);
    check("wrap_7ffe", ram[15'h7FFE], 32'd0);
    check("wrap_7fff", ram[15'h7FFF], 32'd1);
    check("wrap_0000", ram[15'h0000], 32'd2);
    check("wrap_0001", ram[15'h0001], 32'd3);

    // Verify with a corrupted word: stop at the first mismatch.
    inject(15'h0000, 32'h0000DEAD);
    run_op(1, 1, 15'h7FFE, 16'd4, 32'h0, -1, -1, -100, lat, ncs);
    check("chk_error", 32'(error), 32'd1);
    check("chk_error_addr", 32'(error_addr), 32'h0000);
    check("chk_accesses", 32'(ncs), 32'd3);

    // Zero count: immediate done, no access, sticky error cleared.
    run_op(0, 0, 15'h0200, 16'd0, 32'h1, -1, -1, -100, lat, ncs);
    check("zero_latency", 32'(lat), 32'd0);
    check("zero_accesses", 32'(ncs), 32'd0);
    check("zero_error", 32'(error), 32'd0);

    // Grant withdrawn for three cycles mid-fill.
    run_op(0, 1, 15'h0100, 16'd6, 32'h1000, -1, -1, 3, lat, ncs);
    check("grant_latency", 32'(lat), 32'd14);
    check("grant_accesses", 32'(ncs), 32'd6);
    for (int k = 0; k < 6; k++) check("grant_word", ram[15'h0100 + k], 32'h1000 + k);

    // Abort raised during the second access of ten.
    run_op(0, 0, 15'h0300, 16'd10, 32'h12345678, 2, -1, -100, lat, ncs);
    check("abort_accesses", 32'(ncs), 32'd2);
    check("abort_word1", ram[15'h0301], 32'h12345678);
    check("abort_word2", ram[15'h0302], 32'h0);
    run_op(1, 0, 15'h0300, 16'd3, 32'h12345678, -1, -1, -100, lat, ncs);
    check("abort_chk_addr", 32'(error_addr), 32'h0302);

    // Reset while an access is outstanding.
    mode = 1'b0; incr = 1'b1; base_addr = 15'h0400; word_count = 16'd10;
    pattern = 32'h55; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_cs", 32'(mem_cs), 32'd0);
    check("mrst_we", 32'(mem_we), 32'd0);
    check("mrst_addr", 32'(mem_address), 32'd0);
    check("mrst_wdata", mem_write_data, 32'd0);
    check("mrst_error", 32'(error), 32'd0);
    check("mrst_error_addr", 32'(error_addr), 32'd0);
    reset_n = 1'b1;
    tick();

    // Random fills, aborts, ignored restarts and verifies under random grant.
    grant_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      logic [AW-1:0] b;
      logic [CW-1:0] c;
      logic [31:0]   p;
      bit            inc;
      int            ab, rs;
      b   = AW'($urandom);
      c   = CW'($urandom_range(0, 12));
      p   = $urandom;
      inc = 1'($urandom_range(0, 1));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      rs  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_op(0, inc, b, c, p, ab, rs, -100, lat, ncs);
      if (c != 0 && $urandom_range(0, 2) == 0)
        inject(AW'(int'(b) + int'($urandom_range(0, int'(c) - 1))), $urandom);
      run_op(1, inc, b, c, p, -1, -1, -100, lat, ncs);
      for (int k = 0; k < int'(c); k++)
        check("ram_vs_model", ram[AW'(int'(b) + k)], golden[AW'(int'(b) + k)]);
    end
    grant_rand = 1'b0;
    mem_grant  = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
